// File: rtl/cntb_run_scan.sv
// Multi-cycle run-length scanner: counts consecutive bits equal to a match value,
// starting at a selectable index, CHUNK bits per cycle toward the LSB or the MSB.
module cntb_run_scan #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs0_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            dir_i,
  input  logic [1:0]      sel_i,
  output logic            done_o,
  output logic [XLEN-1:0] rd_o
);

  localparam int unsigned IDX_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [IDX_W-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              m_q, m_d;
  logic [IDX_W:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   rd_q, rd_d;

  logic [IDX_W-1:0]  idx;
  logic              start_m;
  logic [IDX_W:0]    k;
  logic              run;
  logic              bit_ok;
  logic [IDX_W:0]    p_up;
  logic              next_ok;
  logic              unused_rs1;

  assign idx        = rs1_i[IDX_W-1:0];
  assign unused_rs1 = ^rs1_i[XLEN-1:IDX_W];

  always_comb begin
    case (sel_i)
      2'b01:   start_m = 1'b1;
      2'b10:   start_m = 1'b0;
      default: start_m = rs0_i[idx];
    endcase
  end

  // Leading-match count over the current window; out-of-range positions end the run.
  always_comb begin
    k      = '0;
    run    = 1'b1;
    bit_ok = 1'b0;
    p_up   = '0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      bit_ok = 1'b0;
      if (dir_q) begin
        p_up = {1'b0, pos_q} + (IDX_W+1)'(j);
        if (p_up < (IDX_W+1)'(XLEN))
          bit_ok = (data_q[p_up[IDX_W-1:0]] == m_q);
      end else begin
        if (IDX_W'(j) <= pos_q)
          bit_ok = (data_q[pos_q - IDX_W'(j)] == m_q);
      end
      if (run && bit_ok)
        k = k + (IDX_W+1)'(1);
      else
        run = 1'b0;
    end
  end

  always_comb begin
    if (dir_q)
      next_ok = ({1'b0, pos_q} + (IDX_W+1)'(CHUNK)) < (IDX_W+1)'(XLEN);
    else
      next_ok = {1'b0, pos_q} >= (IDX_W+1)'(CHUNK);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    ready_o = 1'b0;
    done_o  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          data_d  = rs0_i;
          pos_d   = idx;
          dir_d   = dir_i;
          m_d     = start_m;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = cnt_q + k;
        if (k == (IDX_W+1)'(CHUNK) && next_ok) begin
          pos_d = dir_q ? pos_q + IDX_W'(CHUNK) : pos_q - IDX_W'(CHUNK);
        end else begin
          rd_d    = XLEN'(cnt_q + k);
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides every transition and suppresses the result update and pulse.
    if (flush_i) begin
      state_d = IDLE;
      rd_d    = rd_q;
      done_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      m_q     <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_o = rd_q;

endmodule

// File: tb/tb_cntb_run_scan.sv
// Self-checking bench for cntb_run_scan (CHUNK=8 and CHUNK=1 instances).
module tb_cntb_run_scan;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic        flush0, flush1;
  logic [31:0] rs0, rs1;
  logic        dir;
  logic [1:0]  sel;
  logic        ready0, ready1, done0, done1;
  logic [31:0] rd0, rd1;

  int checks = 0;
  int errors = 0;

  cntb_run_scan #(.XLEN(32), .CHUNK(8)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .ready_o(ready0),
    .flush_i(flush0), .rs0_i(rs0), .rs1_i(rs1), .dir_i(dir), .sel_i(sel),
    .done_o(done0), .rd_o(rd0)
  );

  cntb_run_scan #(.XLEN(32), .CHUNK(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .ready_o(ready1),
    .flush_i(flush1), .rs0_i(rs0), .rs1_i(rs1), .dir_i(dir), .sel_i(sel),
    .done_o(done1), .rd_o(rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the bits, then derive the window count from run length vs. room left.
  function automatic void model(input logic [31:0] d, input int idx, input bit dn,
                                input logic [1:0] sl, input int chunk,
                                output int len, output int s);
    bit m;
    int p, avail;
    if (sl == 2'b01)      m = 1'b1;
    else if (sl == 2'b10) m = 1'b0;
    else                  m = d[idx];
    len = 0;
    p   = idx;
    while (p >= 0 && p < 32 && d[p] == m) begin
      len++;
      p = dn ? p + 1 : p - 1;
    end
    avail = dn ? 32 - idx : idx + 1;
    s = (len == avail && (len % chunk) == 0) ? len / chunk : len / chunk + 1;
  endfunction

  function automatic logic cur_done(input int which);
    return which != 0 ? done1 : done0;
  endfunction

  function automatic logic cur_ready(input int which);
    return which != 0 ? ready1 : ready0;
  endfunction

  function automatic logic [31:0] cur_rd(input int which);
    return which != 0 ? rd1 : rd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int which, input logic [31:0] d, input int idx, input bit dn,
                       input logic [1:0] sl, input string tag);
    int len, s, cyc;
    logic seen;
    model(d, idx, dn, sl, (which != 0) ? 1 : 8, len, s);
    rs0 = d;
    rs1 = ($urandom() & 32'hFFFF_FFE0) | 32'(idx);
    dir = dn;
    sel = sl;
    if (which != 0) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    rs0 = $urandom();
    cyc  = 1;
    seen = cur_done(which);
    while (!seen && cyc < 40) begin
      check({tag, "_busy"}, 32'(cur_ready(which)), 32'd0);
      tick();
      cyc++;
      seen = cur_done(which);
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(s + 1));
    check({tag, "_rd"}, cur_rd(which), 32'(len));
    check({tag, "_rdy_in_done"}, 32'(cur_ready(which)), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(cur_done(which)), 32'd0);
    check({tag, "_idle"}, 32'(cur_ready(which)), 32'd1);
  endtask

  initial begin
    int len, s, cyc, idx;
    logic seen;
    logic [31:0] d, prior;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    rs0    = '0;
    rs1    = '0;
    dir    = 1'b0;
    sel    = 2'b00;
    #3;
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_rd", rd0, 32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    #9 rst_n = 1'b1;
    tick();

    do_op(0, 32'hFFFF0000, 31, 1'b0, 2'b00, "hi16");
    check("hi16_const", rd0, 32'd16);
    do_op(0, 32'hFFFFFFFF, 31, 1'b0, 2'b00, "all_dn");
    check("all_dn_const", rd0, 32'd32);
    do_op(0, 32'hFFFFFFFF, 0, 1'b1, 2'b00, "all_up");
    do_op(0, 32'h00000001, 0, 1'b1, 2'b00, "one_up");
    do_op(0, 32'h000000F0, 4, 1'b1, 2'b10, "zero_miss");
    check("zero_miss_const", rd0, 32'd0);
    do_op(0, 32'h000000F0, 4, 1'b1, 2'b01, "ones4");
    check("ones4_const", rd0, 32'd4);
    do_op(0, 32'h00FF0000, 24, 1'b1, 2'b11, "sel11");
    do_op(0, 32'hFF000000, 24, 1'b1, 2'b01, "top8");
    do_op(1, 32'h0000001F, 0, 1'b1, 2'b01, "c1_run5");
    check("c1_run5_const", rd1, 32'd5);
    do_op(1, 32'h80000000, 31, 1'b1, 2'b00, "c1_edge");

    // start held high through the scan with operands changing underneath
    model(32'h0FFFFF00, 27, 1'b0, 2'b01, 8, len, s);
    rs0 = 32'h0FFFFF00; rs1 = 32'd27; dir = 1'b0; sel = 2'b01; start0 = 1'b1;
    tick();
    rs0 = 32'h00000000; rs1 = 32'd3; dir = 1'b1; sel = 2'b10;
    cyc = 1;
    seen = done0;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      seen = done0;
    end
    start0 = 1'b0;
    check("hold_done", 32'(seen), 32'd1);
    check("hold_lat", 32'(cyc), 32'(s + 1));
    check("hold_rd", rd0, 32'(len));
    tick();
    check("hold_idle", 32'(ready0), 32'd1);

    // flush in cycle 2 of a four-window scan
    prior = rd0;
    rs0 = 32'hFFFFFFFF; rs1 = 32'd31; dir = 1'b0; sel = 2'b00; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    flush0 = 1'b1;
    check("flush_nodone_now", 32'(done0), 32'd0);
    tick();
    flush0 = 1'b0;
    check("flush_ready", 32'(ready0), 32'd1);
    check("flush_rd_kept", rd0, prior);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | done0;
    end
    check("flush_no_done", 32'(seen), 32'd0);
    check("flush_rd_kept2", rd0, prior);

    // flush together with start in IDLE drops the start
    rs0 = 32'h0000FFFF; rs1 = 32'd0; dir = 1'b1; sel = 2'b00;
    flush0 = 1'b1; start0 = 1'b1;
    tick();
    flush0 = 1'b0; start0 = 1'b0;
    check("flush_start_ready", 32'(ready0), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | done0;
    end
    check("flush_start_no_done", 32'(seen), 32'd0);

    // randomized operations on both instances
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       d = $urandom();
        1:       d = 32'hFFFFFFFF;
        2:       d = 32'h00000000;
        default: d = ~(32'hFFFFFFFF << $urandom_range(0, 31)) ^ (32'(1) << $urandom_range(0, 31));
      endcase
      idx = $urandom_range(0, 31);
      do_op(n % 2, d, idx, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), "rand");
    end

    // asynchronous reset in the middle of a scan
    rs0 = 32'hFFFFFFFF; rs1 = 32'd0; dir = 1'b1; sel = 2'b00; start0 = 1'b1; start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_rd", rd0, 32'd0);
    check("arst_ready", 32'(ready0), 32'd1);
    check("arst_done", 32'(done0), 32'd0);
    check("arst_rd1", rd1, 32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | done0 | done1;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    check("arst_idle", 32'(ready0), 32'd1);
    do_op(0, 32'h00000F00, 11, 1'b0, 2'b00, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
